rank_access_arbiter: RTL
========================

RANK_ACCESS_ARBITER -- requirements
Module: rank_access_arbiter

Interface
REQ-001 Parameter BANKADDR_WIDTH, default 9, SHALL set the rank word-address width (upper 2 bits select bank, lower bits select word).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data width.
REQ-003 Parameter READ_LAT, default 3, range 2-15, SHALL set the number of cycles mem_be is held per access before data is sampled.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port list, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  access request, level, held until ack
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  BANKADDR_WIDTH  rank word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_WIDTH  read data, shared, valid while ack0 or ack1 is high
- grant  out  1  index of the port owning the current transaction
- busy  out  1  high in any state other than IDLE
- mem_bankAddr  out  BANKADDR_WIDTH  to rank bankAddr
- mem_dataIn  out  DATA_WIDTH  to rank dataIn
- mem_wr  out  1  to rank wr
- mem_be  out  1  to rank be
- mem_dataOut  in  DATA_WIDTH  from rank dataOut

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCESS and DONE; all outputs SHALL be registered.
REQ-007 In IDLE with any req high, the block SHALL select a port per REQ-013, latch its wr/addr/wdata into mem_wr/mem_bankAddr/mem_dataIn, set grant, load the down-counter with READ_LAT-1, and enter ACCESS.
REQ-008 In ACCESS, mem_be SHALL be 1 and mem_bankAddr/mem_dataIn/mem_wr SHALL stay constant. The counter SHALL decrement each cycle, and the block SHALL enter DONE when the counter reaches 0, giving exactly READ_LAT cycles with mem_be=1.
REQ-009 On the ACCESS-to-DONE edge of a read, rdata SHALL capture mem_dataOut. On a write, rdata SHALL keep its previous value.
REQ-010 In DONE, mem_be SHALL be 0 and ack[grant] SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-011 Latency SHALL be as follows: with req sampled in IDLE at edge N, mem_be is high for cycles N+1..N+READ_LAT and ack is high at cycle N+READ_LAT+1. The minimum spacing between consecutive grants SHALL be READ_LAT+2 cycles.
REQ-012 Requesters SHALL keep req and fields stable until ack. Changes to req or fields during ACCESS/DONE SHALL be ignored. A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-013 Arbitration SHALL follow REQ-020/REQ-021. With a single request, that port SHALL always win.
REQ-014 A request dropped before grant SHALL produce no access and no ack.
REQ-015 mem_bankAddr, mem_dataIn and mem_wr SHALL hold their last values in IDLE. mem_be SHALL be 0 in IDLE and DONE.

Reset
REQ-016 While rst is high at a clk edge, the following SHALL apply: state=IDLE, mem_be=0, mem_wr=0, mem_bankAddr=0, mem_dataIn=0, ack0=ack1=0, rdata=0, grant=0, busy=0, counter=0, last-grant=1.
REQ-017 Reset asserted during ACCESS SHALL abort the transaction with no ack. The rank contents at the aborted address are undefined.
REQ-018 The first grant after reset SHALL go to port 0 when both ports request.

Configuration
REQ-019 Macro RANK_ARB_RR_FAIR_EN SHALL select the arbitration policy.
REQ-020 With RANK_ARB_RR_FAIR_EN defined, on simultaneous requests the block SHALL grant the port not granted last. The last-grant register SHALL update on each IDLE-to-ACCESS transition.
REQ-021 Without RANK_ARB_RR_FAIR_EN, port 0 SHALL have fixed priority, the last-grant register SHALL NOT be implemented, and REQ-018 still holds.

Verification (READ_LAT=3)
REQ-022 Write: req0=1, wr0=1, addr0=0x085, wdata0=0xA5 at edge N -> mem_be=1 for cycles N+1..N+3 with mem_bankAddr=0x085 and mem_dataIn=0xA5; ack0=1 at N+4 only; ack1 stays 0.
REQ-023 Read-back: after REQ-022, read via port 1 at 0x085 -> rdata=0xA5 with ack1=1 and grant=1; rdata remains 0xA5 afterwards.
REQ-024 Contention: req0 and req1 held high continuously -> with RANK_ARB_RR_FAIR_EN the grants alternate 0,1,0,1 every 5 cycles; without the macro, port 0 is granted every time.
REQ-025 Bank boundaries: write 0x11, 0x22, 0x33, 0x44 to addresses 0x07F, 0x080, 0x0FF, 0x1FF, then read all four -> each address returns its own value.
REQ-026 Reset mid-access: assert rst in the second ACCESS cycle of a read -> the next cycle shows mem_be=0, busy=0, rdata=0, no ack; the next request is served normally.
REQ-027 Withdrawn request: req1 pulsed high for one cycle while busy -> no grant to port 1 and ack1 never asserts.

Source files
------------

// File: rtl/rank_access_arbiter.sv
// ---------------------------------------------------------------------------
// rank_access_arbiter
//
// Purpose:
//   Arbitrates two request ports onto a single memory rank. Each access
//   holds mem_be high for exactly READ_LAT cycles. On the last of those
//   cycles a read captures mem_dataOut into rdata. A one-cycle ack pulse
//   then goes to the owning port. All outputs are registered.
//
// Configuration:
//   RANK_ARB_RR_FAIR_EN  defined   -> round-robin on simultaneous requests
//                        undefined -> fixed priority, port 0 wins
//
// Parameters:
//   BANKADDR_WIDTH  rank word address width (upper 2 bits = bank)
//   DATA_WIDTH      data width
//   READ_LAT        cycles mem_be is held per access (2..15)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, wr0/1            level request (held until ack), 1 = write
//   addr0/1, wdata0/1        request address and write data
//   ack0/1                   one-cycle completion pulse
//   rdata                    read data, valid while ack0 or ack1 is high
//   grant                    index of the port owning the transaction
//   busy                     high whenever the FSM is not IDLE
//   mem_bankAddr/dataIn/wr/be, mem_dataOut   rank interface
//
// Handshake: a port raises req with stable wr/addr/wdata and holds them
// until it sees its ack. Changes while the block is busy are not observed.
// A req still high in the IDLE cycle after ack starts a new transaction.
// ---------------------------------------------------------------------------
module rank_access_arbiter #(
  parameter int BANKADDR_WIDTH = 9,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LAT       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      wr0,
  input  logic                      wr1,
  input  logic [BANKADDR_WIDTH-1:0] addr0,
  input  logic [BANKADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]     wdata0,
  input  logic [DATA_WIDTH-1:0]     wdata1,
  output logic                      ack0,
  output logic                      ack1,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      grant,
  output logic                      busy,
  output logic [BANKADDR_WIDTH-1:0] mem_bankAddr,
  output logic [DATA_WIDTH-1:0]     mem_dataIn,
  output logic                      mem_wr,
  output logic                      mem_be,
  input  logic [DATA_WIDTH-1:0]     mem_dataOut
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      grant_q, grant_d;
  logic                      busy_q, busy_d;
  logic                      ack0_q, ack0_d;
  logic                      ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [BANKADDR_WIDTH-1:0] mem_bank_addr_q, mem_bank_addr_d;
  logic [DATA_WIDTH-1:0]     mem_data_in_q, mem_data_in_d;
  logic                      mem_wr_q, mem_wr_d;
  logic                      mem_be_q, mem_be_d;
  logic                      sel;

`ifdef RANK_ARB_RR_FAIR_EN
  logic last_q, last_d;

  // On contention, serve the port that did not win last time. last_q
  // resets to 1, so the first contended grant goes to port 0.
  always_comb sel = (req0 && req1) ? ~last_q : req1;
`else
  // Fixed priority: port 0 wins whenever it requests.
  always_comb sel = ~req0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    grant_d         = grant_q;
    ack0_d          = 1'b0;
    ack1_d          = 1'b0;
    rdata_d         = rdata_q;
    mem_bank_addr_d = mem_bank_addr_q;
    mem_data_in_d   = mem_data_in_q;
    mem_wr_d        = mem_wr_q;
    mem_be_d        = 1'b0;
`ifdef RANK_ARB_RR_FAIR_EN
    last_d          = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d         = sel;
          mem_wr_d        = sel ? wr1 : wr0;
          mem_bank_addr_d = sel ? addr1 : addr0;
          mem_data_in_d   = sel ? wdata1 : wdata0;
          mem_be_d        = 1'b1;
          cnt_d           = CNT_W'(READ_LAT - 1);
          state_d         = ACCESS;
`ifdef RANK_ARB_RR_FAIR_EN
          last_d          = sel;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Last enable cycle: the rank's read data is valid now.
          state_d = DONE;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          if (!mem_wr_q) rdata_d = mem_dataOut;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_be_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      grant_q         <= 1'b0;
      busy_q          <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      rdata_q         <= '0;
      mem_bank_addr_q <= '0;
      mem_data_in_q   <= '0;
      mem_wr_q        <= 1'b0;
      mem_be_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      ack0_q          <= ack0_d;
      ack1_q          <= ack1_d;
      rdata_q         <= rdata_d;
      mem_bank_addr_q <= mem_bank_addr_d;
      mem_data_in_q   <= mem_data_in_d;
      mem_wr_q        <= mem_wr_d;
      mem_be_q        <= mem_be_d;
    end
  end

`ifdef RANK_ARB_RR_FAIR_EN
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata        = rdata_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign mem_bankAddr = mem_bank_addr_q;
  assign mem_dataIn   = mem_data_in_q;
  assign mem_wr       = mem_wr_q;
  assign mem_be       = mem_be_q;

endmodule
